// File: rtl/ubus_arbiter_rr.sv
// UBUS bus-phase controller and arbiter: sequences Start/Address/Data/No-op and grants one master per Start.
// Optional Data-phase watchdog enabled by defining UBUS_ARB_WATCHDOG_EN.
module ubus_arbiter_rr #(
   parameter int NUM_MASTERS = 4,
   parameter int ARB_MODE    = 0,
   parameter int ID_W        = $clog2(NUM_MASTERS),
   parameter int MAX_WAIT    = 64
) (
   input  logic                   ubus_clock,
   input  logic                   ubus_reset_n,
   input  logic [NUM_MASTERS-1:0] ubus_req,
   output logic [NUM_MASTERS-1:0] ubus_gnt,
   output logic [ID_W-1:0]        ubus_gnt_id,
   output logic                   ubus_start,
   output logic                   ubus_read,
   output logic                   ubus_write,
   input  logic                   ubus_bip,
   input  logic                   ubus_wait,
   input  logic                   ubus_error,
   output logic                   ubus_timeout
);

   typedef enum logic [2:0] {
      ST_RST_EXIT = 3'd0,
      ST_START    = 3'd1,
      ST_NOP      = 3'd2,
      ST_ADDR     = 3'd3,
      ST_DATA     = 3'd4
   } state_t;

   localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
   localparam logic [ID_W-1:0]        PTR_RST  = ID_W'(NUM_MASTERS - 1);

   // Elaboration-time guard against illegal configurations.
   if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || MAX_WAIT < 2 || MAX_WAIT > 65535) begin : g_bad_cfg
      $fatal(1, "ubus_arbiter_rr: illegal NUM_MASTERS or MAX_WAIT");
   end

   state_t                  state_r, state_s;
   logic                    start_r, start_s;
   logic                    rw_en_r, rw_en_s;
   logic [NUM_MASTERS-1:0]  gnt_r;
   logic [ID_W-1:0]         gnt_id_r;
   logic [ID_W-1:0]         ptr_r;
   logic [ID_W-1:0]         base_s;
   logic [ID_W-1:0]         cand_s;
   logic [ID_W-1:0]         win_s;
   logic                    found_s;

`ifdef UBUS_ARB_WATCHDOG_EN
   localparam logic [15:0] WD_LIMIT = 16'(MAX_WAIT - 1);
   logic [15:0] wd_cnt_r, wd_cnt_s;
   logic        timeout_r, timeout_s;
`endif

   // Phase sequencing and watchdog next-state logic.
   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
`ifdef UBUS_ARB_WATCHDOG_EN
      wd_cnt_s  = wd_cnt_r;
      timeout_s = 1'b0;
`endif
      case (state_r)
         ST_RST_EXIT: begin
            start_s = 1'b1;
            state_s = ST_START;
         end
         ST_START: begin
            if (|gnt_r) begin
               state_s = ST_ADDR;
            end else begin
               state_s = ST_NOP;
            end
         end
         ST_NOP: begin
            start_s = 1'b1;
            state_s = ST_START;
         end
         ST_ADDR: begin
            state_s = ST_DATA;
`ifdef UBUS_ARB_WATCHDOG_EN
            wd_cnt_s = 16'd0;
`endif
         end
         ST_DATA: begin
            // Error wins over a simultaneous wait.
            if (ubus_error || (!ubus_bip && !ubus_wait)) begin
               start_s = 1'b1;
               state_s = ST_START;
            end else begin
`ifdef UBUS_ARB_WATCHDOG_EN
               if (wd_cnt_r == WD_LIMIT) begin
                  start_s   = 1'b1;
                  state_s   = ST_START;
                  timeout_s = 1'b1;
                  wd_cnt_s  = 16'd0;
               end else begin
                  state_s  = ST_DATA;
                  wd_cnt_s = wd_cnt_r + 16'd1;
               end
`else
               state_s = ST_DATA;
`endif
            end
         end
         default: begin
            start_s = 1'b0;
            state_s = ST_RST_EXIT;
         end
      endcase
   end

   // Bus lines are driven low only in a No-op cycle (Start with nobody granted).
   always_comb begin
      rw_en_s = start_r && !(|gnt_r);
   end

   // Phase state register on the rising edge.
   always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
      if (!ubus_reset_n) begin
         state_r <= ST_RST_EXIT;
         start_r <= 1'b0;
         rw_en_r <= 1'b0;
      end else begin
         state_r <= state_s;
         start_r <= start_s;
         rw_en_r <= rw_en_s;
      end
   end

`ifdef UBUS_ARB_WATCHDOG_EN
   // Watchdog counter and one-cycle timeout pulse.
   always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
      if (!ubus_reset_n) begin
         wd_cnt_r  <= 16'd0;
         timeout_r <= 1'b0;
      end else begin
         wd_cnt_r  <= wd_cnt_s;
         timeout_r <= timeout_s;
      end
   end

   assign ubus_timeout = timeout_r;
`else
   assign ubus_timeout = 1'b0;
`endif

   // Winner search: fixed mode scans from index 0, round-robin from the slot after the last grant.
   always_comb begin
      base_s  = (ARB_MODE == 1) ? ptr_r : PTR_RST;
      found_s = 1'b0;
      win_s   = {ID_W{1'b0}};
      cand_s  = {ID_W{1'b0}};
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand_s = ID_W'((int'(base_s) + 1 + i) % NUM_MASTERS);
         if (!found_s && ubus_req[cand_s]) begin
            found_s = 1'b1;
            win_s   = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grant register on the falling edge so a grant spans negedge to negedge.
   always_ff @(negedge ubus_clock or negedge ubus_reset_n) begin
      if (!ubus_reset_n) begin
         gnt_r    <= {NUM_MASTERS{1'b0}};
         gnt_id_r <= {ID_W{1'b0}};
         ptr_r    <= PTR_RST;
      end else if (start_r && found_s) begin
         gnt_r    <= ONE_HOT0 << win_s;
         gnt_id_r <= win_s;
         ptr_r    <= win_s;
      end else begin
         gnt_r    <= {NUM_MASTERS{1'b0}};
         gnt_id_r <= {ID_W{1'b0}};
      end
   end

   assign ubus_gnt    = gnt_r;
   assign ubus_gnt_id = gnt_id_r;
   assign ubus_start  = start_r;
   assign ubus_read   = rw_en_r ? 1'b0 : 1'bz;
   assign ubus_write  = rw_en_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ubus_arbiter_rr.sv
// Bench for ubus_arbiter_rr: a fixed-priority and a round-robin instance share stimulus and are
// checked phase by phase against a transaction-level model of grants and Data-phase length.
module tb_ubus_arbiter_rr;

   localparam int N = 4;
`ifdef UBUS_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic         bip, wt, err;
   logic [N-1:0] gnt_f, gnt_r;
   logic [1:0]   id_f, id_r;
   logic         start_f, start_r, to_f, to_r;
   wire          rd_f, wr_f, rd_r, wr_r;

   pullup (rd_f);
   pullup (wr_f);
   pullup (rd_r);
   pullup (wr_r);

   int checks = 0;
   int errors = 0;
   int rr_last = N - 1;

   always #5 clk = ~clk;

   ubus_arbiter_rr #(.NUM_MASTERS(N), .ARB_MODE(0), .MAX_WAIT(8)) dut_f (
      .ubus_clock(clk), .ubus_reset_n(rst_n), .ubus_req(req), .ubus_gnt(gnt_f),
      .ubus_gnt_id(id_f), .ubus_start(start_f), .ubus_read(rd_f), .ubus_write(wr_f),
      .ubus_bip(bip), .ubus_wait(wt), .ubus_error(err), .ubus_timeout(to_f));

   ubus_arbiter_rr #(.NUM_MASTERS(N), .ARB_MODE(1), .MAX_WAIT(8)) dut_r (
      .ubus_clock(clk), .ubus_reset_n(rst_n), .ubus_req(req), .ubus_gnt(gnt_r),
      .ubus_gnt_id(id_r), .ubus_start(start_r), .ubus_read(rd_r), .ubus_write(wr_r),
      .ubus_bip(bip), .ubus_wait(wt), .ubus_error(err), .ubus_timeout(to_r));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int fixed_win(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic int rr_win(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] v;
      v = '0;
      if (w >= 0) v[w] = 1'b1;
      return v;
   endfunction

   task automatic chk_bus(input string tag, input logic s, input logic rw, input logic to);
      chk({tag, "_start_f"}, start_f, s);
      chk({tag, "_start_r"}, start_r, s);
      chk({tag, "_rd_f"}, rd_f, rw);
      chk({tag, "_wr_r"}, wr_r, rw);
      chk({tag, "_to_f"}, to_f, to);
      chk({tag, "_to_r"}, to_r, to);
   endtask

   // Observes a Start cycle, presents r, then checks the grant in the following cycle.
   task automatic start_cycle(input logic [N-1:0] r);
      int ef, er;
      chk("start_on_f", start_f, 1);
      chk("start_on_r", start_r, 1);
      chk("gnt_pre_f", gnt_f, 0);
      chk("gnt_pre_r", gnt_r, 0);
      req = r; bip = 1'b0; wt = 1'b0; err = 1'b0;
      ef = fixed_win(r);
      er = rr_win(r, rr_last);
      step();
      chk("gnt_f", gnt_f, onehot(ef));
      chk("gnt_r", gnt_r, onehot(er));
      if (r != '0) begin
         chk("id_f", id_f, ef);
         chk("id_r", id_r, er);
         rr_last = er;
      end
      chk_bus("after_start", 1'b0, (r == '0) ? 1'b0 : 1'b1, 1'b0);
      req = N'($urandom);
   endtask

   // One Start phase plus Data phase; lat counts cycles from ADDR to the next Start.
   task automatic run_phase(input logic [N-1:0] r, input int stall, input int err_at,
                            input bit rand_stall, output int lat);
      bit         done;
      logic [1:0] v;
      lat = 0;
      start_cycle(r);
      if (r == '0) begin
         step();
         return;
      end
      step();
      lat = 1;
      done = 1'b0;
      for (int k = 0; !done && k < 64; k++) begin
         chk_bus("data", 1'b0, 1'b1, 1'b0);
         chk("data_gnt_f", gnt_f, 0);
         chk("data_gnt_r", gnt_r, 0);
         if (k == err_at) begin
            err = 1'b1; wt = 1'b1; bip = 1'($urandom); done = 1'b1;
         end else if (k < stall) begin
            v = rand_stall ? 2'($urandom_range(1, 3)) : 2'b10;
            bip = v[0]; wt = v[1]; err = 1'b0;
         end else begin
            bip = 1'b0; wt = 1'b0; err = 1'b0; done = 1'b1;
         end
         req = N'($urandom);
         step();
         lat++;
      end
      bip = 1'b0; wt = 1'b0; err = 1'b0;
   endtask

   initial begin
      int  lat, r, stall, err_at;
      bit  hit;
      rst_n = 1'b0; req = '0; bip = 1'b0; wt = 1'b0; err = 1'b0;
      step();
      step();
      chk_bus("reset", 1'b0, 1'b1, 1'b0);
      chk("reset_gnt_f", gnt_f, 0);
      chk("reset_id_r", id_r, 0);
      rst_n = 1'b1;
      step();

      // Idle bus: Start / No-op alternation with read/write driven low in No-op.
      for (int i = 0; i < 3; i++) run_phase(4'b0000, 0, -1, 1'b0, lat);

      // Round-robin order 0,1,2,3,0 with single-cycle transfers.
      for (int i = 0; i < 5; i++) run_phase(4'b1111, 0, -1, 1'b0, lat);

      // Fixed priority with masters 1 and 3 requesting.
      for (int i = 0; i < 3; i++) run_phase(4'b1010, 0, -1, 1'b0, lat);

      run_phase(4'b0100, 5, -1, 1'b0, lat);
      chk("wait5_latency", lat, 7);

      run_phase(4'b1000, 3, 0, 1'b0, lat);
      chk("error_latency", lat, 2);

      // Long stall: watchdog fires 8 cycles after Data entry only when enabled.
      start_cycle(4'b0001);
      step();
      wt = 1'b1;
      hit = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (WD && k == 8) begin
            chk_bus("wd_pulse", 1'b1, 1'b1, 1'b1);
            hit = 1'b1;
            break;
         end
         chk_bus("wd_stall", 1'b0, 1'b1, 1'b0);
         step();
      end
      wt = 1'b0;
      if (!hit) begin
         chk_bus("wd_still_data", 1'b0, 1'b1, 1'b0);
         step();
      end
      run_phase(4'b0010, 0, -1, 1'b0, lat);

      for (int i = 0; i < 40; i++) begin
         r      = $urandom_range(0, 15);
         stall  = $urandom_range(0, 5);
         err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, stall) : -1;
         run_phase(N'(r), stall, err_at, 1'b1, lat);
         chk("rand_latency", lat, (r == 0) ? 0 : ((err_at >= 0) ? err_at + 2 : stall + 2));
      end

      // Reset in the middle of a Data phase.
      start_cycle(4'b0110);
      step();
      wt = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk_bus("midreset", 1'b0, 1'b1, 1'b0);
      chk("midreset_gnt_r", gnt_r, 0);
      chk("midreset_id_f", id_f, 0);
      rr_last = N - 1;
      step();
      step();
      wt = 1'b0;
      rst_n = 1'b1;
      step();
      run_phase(4'b1111, 0, -1, 1'b0, lat);
      run_phase(4'b1111, 1, -1, 1'b1, lat);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
